// File: rtl/sram_resp_pkg.sv
// Shared types and constants for the SRAM wait-state responder.
// The LFSR helpers are only used when SRAM_RESP_JITTER_EN is defined.
package sram_resp_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      DONE = 2'd2
   } respState_t;

   // Counter width: 15 base wait states plus up to 3 jitter states fit comfortably
   localparam int WAIT_W = 6;

   localparam logic [15:0] LFSR_SEED = 16'hACE1;
   // Galois form of taps 16,14,13,11 (right-shifting register)
   localparam logic [15:0] LFSR_TAPS = 16'hB400;

   function automatic logic [15:0] lfsrNext(input logic [15:0] s);
      return s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
   endfunction

endpackage

// File: rtl/sram_resp_array.sv
// Single-port word array with byte-lane writes and a read-before-write
// output register. The storage is never reset; only the output register is.
module sram_resp_array
   import sram_resp_pkg::*;
#(
   parameter int DEPTH_LOG2 = 14
) (
   input  logic                  clk,
   input  logic                  resetn,
   input  logic                  access,
   input  logic                  clear,
   input  logic [3:0]            wen,
   input  logic [DEPTH_LOG2-1:0] addr,
   input  logic [31:0]           wdata,
   output logic [31:0]           rdata
);

   logic [31:0] mem [2**DEPTH_LOG2];

   // Byte-lane writes on an in-range access
   always_ff @(posedge clk) begin
      if (access) begin
         for (int i = 0; i < 4; i++) begin
            if (wen[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
         end
      end
   end

   // Output register captures the old word; an out-of-range access clears it
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn)     rdata <= '0;
      else if (access) rdata <= mem[addr];
      else if (clear)  rdata <= '0;
   end

endmodule

// File: rtl/sram_wait_responder.sv
// SRAM-style slave responder: accepts a request, stalls the master for
// WAIT_CYCLES extra cycles, then presents read data for one completion cycle.
// Optional feature macro: SRAM_RESP_JITTER_EN adds 0..3 pseudo-random wait
// states per request from a 16-bit Galois LFSR.
module sram_wait_responder
   import sram_resp_pkg::*;
#(
   parameter int          DEPTH_LOG2  = 14,
   parameter int          WAIT_CYCLES = 2,
   parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        req_en,
   input  logic [3:0]  req_wen,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic [31:0] rdata,
   output logic        stall,
   output logic        resp_valid,
   output logic        resp_err
);

   respState_t            state;
   logic [WAIT_W-1:0]     cnt;
   logic                  errQ;
   logic [WAIT_W-1:0]     waitTotal;
   logic [31:0]           byteOffset;
   logic [29:0]           wordOffset;
   logic [DEPTH_LOG2-1:0] wordIdx;
   logic                  inRange;
   logic                  accessNow;

   // Modulo-2^32 offset: anything below BASE_ADDR wraps to a huge index
   assign byteOffset = req_addr - BASE_ADDR;
   assign wordOffset = byteOffset[31:2];
   assign wordIdx    = wordOffset[DEPTH_LOG2-1:0];
   assign inRange    = (wordOffset >> DEPTH_LOG2) == '0;

`ifdef SRAM_RESP_JITTER_EN
   logic [15:0] lfsr;

   assign waitTotal = WAIT_W'(WAIT_CYCLES) + {{(WAIT_W-2){1'b0}}, lfsr[1:0]};

   // Advance once per request accepted in IDLE
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn)                      lfsr <= LFSR_SEED;
      else if (state == IDLE && req_en) lfsr <= lfsrNext(lfsr);
   end
`else
   assign waitTotal = WAIT_W'(WAIT_CYCLES);
`endif

   // The access edge: zero-wait accept in IDLE, or last wait state still requested
   assign accessNow = resetn && req_en &&
                      ((state == IDLE && waitTotal == '0) ||
                       (state == WAIT && cnt == '0));

   assign stall      = req_en && (state != DONE);
   assign resp_valid = (state == DONE);
   assign resp_err   = (state == DONE) && errQ;

   // Request sequencing: IDLE -> WAIT (counting) -> DONE -> IDLE
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state <= IDLE;
         cnt   <= '0;
         errQ  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (req_en) begin
                  if (waitTotal == '0) begin
                     state <= DONE;
                     errQ  <= !inRange;
                  end else begin
                     cnt   <= waitTotal - 1'b1;
                     state <= WAIT;
                  end
               end
            end
            WAIT: begin
               if (!req_en) begin
                  state <= IDLE;
               end else if (cnt != '0) begin
                  cnt <= cnt - 1'b1;
               end else begin
                  state <= DONE;
                  errQ  <= !inRange;
               end
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   sram_resp_array #(
      .DEPTH_LOG2 (DEPTH_LOG2)
   ) u_array (
      .clk    (clk),
      .resetn (resetn),
      .access (accessNow && inRange),
      .clear  (accessNow && !inRange),
      .wen    (req_wen),
      .addr   (wordIdx),
      .wdata  (req_wdata),
      .rdata  (rdata)
   );

endmodule

// File: tb/tb_sram_wait_responder.sv
// Self-checking bench for sram_wait_responder: two instances (2 and 0 wait
// states) driven by directed accesses, checked every cycle against a
// transaction-level model plus literal expectations.
module tb_sram_wait_responder;

   logic        clk = 1'b0;
   logic        resetn = 1'b0;
   logic        reqEn    [2];
   logic [3:0]  reqWen   [2];
   logic [31:0] reqAddr  [2];
   logic [31:0] reqWdata [2];
   logic [31:0] dRdata   [2];
   logic        dStall   [2];
   logic        dValid   [2];
   logic        dErr     [2];

   // Model state and per-cycle expectations
   logic [31:0] expRdata [2];
   logic        expKnown [2];
   logic        expStall [2];
   logic        expValid [2];
   logic        expErr   [2];
   logic [31:0] memM [int];
   logic [15:0] lfsrM [2];
   int          waitM [2];
   logic [31:0] baseM [2];
   int          depthM [2];

   int  checks = 0;
   int  errors = 0;
   int  cyc = 0;
   bit  chkOn = 1'b0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   sram_wait_responder #(.DEPTH_LOG2(6), .WAIT_CYCLES(2), .BASE_ADDR(32'h0000_0000)) dut (
      .clk(clk), .resetn(resetn), .req_en(reqEn[0]), .req_wen(reqWen[0]),
      .req_addr(reqAddr[0]), .req_wdata(reqWdata[0]), .rdata(dRdata[0]),
      .stall(dStall[0]), .resp_valid(dValid[0]), .resp_err(dErr[0]));

   sram_wait_responder #(.DEPTH_LOG2(4), .WAIT_CYCLES(0), .BASE_ADDR(32'h0000_1000)) dut0 (
      .clk(clk), .resetn(resetn), .req_en(reqEn[1]), .req_wen(reqWen[1]),
      .req_addr(reqAddr[1]), .req_wdata(reqWdata[1]), .rdata(dRdata[1]),
      .stall(dStall[1]), .resp_valid(dValid[1]), .resp_err(dErr[1]));

   function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endfunction

   function automatic logic [15:0] refLfsr(input logic [15:0] s);
      logic [15:0] n;
      n = s >> 1;
      if (s[0]) n = n ^ 16'hB400;
      return n;
   endfunction

   function automatic void setIdle(input int d);
      reqEn[d]    = 1'b0;
      expStall[d] = 1'b0;
      expValid[d] = 1'b0;
      expErr[d]   = 1'b0;
   endfunction

   // Single compare process: every negedge, both instances against the model
   initial begin
      forever begin
         @(negedge clk);
         if (chkOn) begin
            for (int d = 0; d < 2; d++) begin
               chk($sformatf("stall%0d", d), 32'(dStall[d]), 32'(expStall[d]));
               chk($sformatf("valid%0d", d), 32'(dValid[d]), 32'(expValid[d]));
               chk($sformatf("err%0d", d), 32'(dErr[d]), 32'(expErr[d]));
               if (expKnown[d]) chk($sformatf("rdata%0d", d), dRdata[d], expRdata[d]);
            end
         end
      end
   end

   task automatic idleCycles(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk); #1;
         setIdle(0);
         setIdle(1);
         @(negedge clk); #1;
      end
   endtask

   // One master transaction; dropAt >= 0 deasserts req_en in that cycle
   task automatic doAccess(input int d, input logic [3:0] wen, input logic [31:0] addr,
                           input logic [31:0] wdata, input int dropAt,
                           output int stallCnt, output int validAt,
                           output logic [31:0] rd, output logic err);
      int          lat;
      int          key;
      logic [31:0] off;
      logic [31:0] idx;
      logic [31:0] merged;
      bit          inR;
      lat = waitM[d];
`ifdef SRAM_RESP_JITTER_EN
      lat = lat + int'(lfsrM[d][1:0]);
`endif
      lfsrM[d] = refLfsr(lfsrM[d]);
      off = addr - baseM[d];
      idx = off >> 2;
      inR = idx < (32'd1 << depthM[d]);
      key = d * 65536 + int'(idx[15:0]);
      stallCnt = 0;
      validAt  = -1;
      rd       = '0;
      err      = 1'b0;
      for (int c = 0; c <= lat + 1; c++) begin
         @(posedge clk); #1;
         setIdle(1 - d);
         reqWen[d]   = wen;
         reqAddr[d]  = addr;
         reqWdata[d] = wdata;
         if (dropAt >= 0 && c == dropAt) begin
            setIdle(d);
         end else if (c <= lat) begin
            reqEn[d]    = 1'b1;
            expStall[d] = 1'b1;
            expValid[d] = 1'b0;
            expErr[d]   = 1'b0;
         end else begin
            // Completion cycle: master may leave req_en up, stall must be low
            expStall[d] = 1'b0;
            expValid[d] = 1'b1;
            if (inR) begin
               expErr[d] = 1'b0;
               if (memM.exists(key)) begin
                  expRdata[d] = memM[key];
                  expKnown[d] = 1'b1;
               end else begin
                  expKnown[d] = 1'b0;
               end
               if (wen == 4'hF) begin
                  memM[key] = wdata;
               end else if (wen != 4'h0) begin
                  if (memM.exists(key)) begin
                     merged = memM[key];
                     for (int b = 0; b < 4; b++)
                        if (wen[b]) merged[8*b +: 8] = wdata[8*b +: 8];
                     memM[key] = merged;
                  end
               end
            end else begin
               expErr[d]   = 1'b1;
               expRdata[d] = '0;
               expKnown[d] = 1'b1;
            end
         end
         @(negedge clk); #1;
         if (dStall[d]) stallCnt++;
         if (dValid[d] && validAt < 0) begin
            validAt = cyc;
            rd      = dRdata[d];
            err     = dErr[d];
         end
         if (dropAt >= 0 && c == dropAt) break;
      end
   endtask

   initial begin
      int          sc, va, va2;
      logic [31:0] rd;
      logic        er;
      int          nReads;
      waitM  = '{2, 0};
      baseM  = '{32'h0000_0000, 32'h0000_1000};
      depthM = '{6, 4};
      for (int d = 0; d < 2; d++) begin
         reqWen[d] = '0; reqAddr[d] = '0; reqWdata[d] = '0;
         setIdle(d);
         expRdata[d] = '0;
         expKnown[d] = 1'b1;
         lfsrM[d]    = 16'hACE1;
      end
      chkOn = 1'b1;
      repeat (3) @(posedge clk);
      #2 resetn = 1'b1;
      @(negedge clk); #1;
      chk("rstRdata", dRdata[0], 32'h0);
      chk("rstStall", 32'(dStall[0]), 32'h0);

      // Full write then readback, two wait states
      doAccess(0, 4'hF, 32'h10, 32'hDEADBEEF, -1, sc, va, rd, er);
`ifndef SRAM_RESP_JITTER_EN
      chk("wrStallCycles", sc, 3);
`endif
      doAccess(0, 4'h0, 32'h10, 32'h0, -1, sc, va, rd, er);
      chk("rdDeadbeef", rd, 32'hDEADBEEF);

      // Byte-lane write into a known word
      doAccess(0, 4'hF, 32'h20, 32'h11223344, -1, sc, va, rd, er);
      doAccess(0, 4'b0010, 32'h20, 32'h0000AB00, -1, sc, va, rd, er);
      chk("laneOld", rd, 32'h11223344);
      doAccess(0, 4'h0, 32'h20, 32'h0, -1, sc, va, rd, er);
      chk("laneMerged", rd, 32'h1122AB44);

      // Zero-wait instance: back-to-back reads separated by one IDLE gap
      doAccess(1, 4'hF, 32'h1000, 32'hA5A50001, -1, sc, va, rd, er);
      doAccess(1, 4'hF, 32'h1004, 32'hA5A50002, -1, sc, va, rd, er);
      doAccess(1, 4'h0, 32'h1000, 32'h0, -1, sc, va, rd, er);
      chk("z0Data", rd, 32'hA5A50001);
`ifndef SRAM_RESP_JITTER_EN
      chk("z0StallCycles", sc, 1);
`endif
      doAccess(1, 4'h0, 32'h1004, 32'h0, -1, sc, va2, rd, er);
      chk("z1Data", rd, 32'hA5A50002);
`ifndef SRAM_RESP_JITTER_EN
      chk("doneSpacing", va2 - va, 2);
`endif

      // Write abandoned in the second wait cycle leaves the word alone
      doAccess(0, 4'hF, 32'h30, 32'hCAFEF00D, -1, sc, va, rd, er);
      doAccess(0, 4'hF, 32'h30, 32'h12345678, 2, sc, va, rd, er);
      chk("dropNoValid", va, -1);
      idleCycles(1);
      doAccess(0, 4'h0, 32'h30, 32'h0, -1, sc, va, rd, er);
      chk("dropReadback", rd, 32'hCAFEF00D);

      // Out-of-range: one past the end, and a wrap below BASE_ADDR
      doAccess(0, 4'hF, 32'h0, 32'h0BADF00D, -1, sc, va, rd, er);
      doAccess(0, 4'hF, 32'h100, 32'hFFFFFFFF, -1, sc, va, rd, er);
      chk("oorErr", 32'(er), 32'h1);
      chk("oorRdata", rd, 32'h0);
      doAccess(0, 4'h0, 32'h0, 32'h0, -1, sc, va, rd, er);
      chk("oorUnchanged", rd, 32'h0BADF00D);
      doAccess(1, 4'h0, 32'h0FFC, 32'h0, -1, sc, va, rd, er);
      chk("wrapErr", 32'(er), 32'h1);

      // Reset pulse while a write sits in WAIT
      @(posedge clk); #1;
      setIdle(1);
      reqEn[0] = 1'b1; reqWen[0] = 4'hF; reqAddr[0] = 32'h0; reqWdata[0] = 32'h11111111;
      expStall[0] = 1'b1;
      @(posedge clk); #1;
      @(negedge clk); #2;
      resetn = 1'b0;
      setIdle(0);
      setIdle(1);
      for (int d = 0; d < 2; d++) begin
         expRdata[d] = '0;
         expKnown[d] = 1'b1;
         lfsrM[d]    = 16'hACE1;
      end
      #2 resetn = 1'b1;
      @(posedge clk); #1;
      @(negedge clk); #1;
      chk("rstMidStall", 32'(dStall[0]), 32'h0);
      chk("rstMidValid", 32'(dValid[0]), 32'h0);
      doAccess(0, 4'h0, 32'h0, 32'h0, -1, sc, va, rd, er);
      chk("rstNoWrite", rd, 32'h0BADF00D);

      // Latency sweep of repeated reads
`ifdef SRAM_RESP_JITTER_EN
      nReads = 100;
`else
      nReads = 8;
`endif
      for (int i = 0; i < nReads; i++) begin
         doAccess(0, 4'h0, 32'h10, 32'h0, -1, sc, va, rd, er);
         chk("latRange", 32'(sc >= 3 && sc <= 6), 32'h1);
         chk("loopData", rd, 32'hDEADBEEF);
      end
      idleCycles(2);

      chkOn = 1'b0;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/sram_wait_responder.md
# sram_wait_responder

Memory-side responder for the CPU's SRAM-style fetch/data port: it accepts the request the pipeline drives (enable, byte write strobes, address, write data) and returns read data after a configurable number of wait states, raising a stall that feeds the pipeline's `stall_by_iram`/data-stall input. It owns a word-addressed backing array with byte-lane writes. It is the slave end of the interface whose master side is the pipeline datapath, and is instantiated once for instruction and once for data in simulation and FPGA SoC builds.

## Interface
Parameters:
- `DEPTH_LOG2`, 14: array holds 2^DEPTH_LOG2 32-bit words.
- `WAIT_CYCLES`, 2: extra wait states per access, 0..15.
- `BASE_ADDR`, 32'h0000_0000: byte address mapped to word 0.

Ports:
- `clk` in 1: sole clock, rising edge.
- `resetn` in 1: asynchronous, active-low reset.
- `req_en` in 1: request valid; master holds all `req_*` stable while `stall`=1.
- `req_wen` in 4: byte write strobes, bit i → `req_wdata[8i+7:8i]`; 0 = read.
- `req_addr` in 32: byte address, bits [1:0] ignored.
- `req_wdata` in 32: write data.
- `rdata` out 32: read data, valid only while `resp_valid`=1.
- `stall` out 1: combinational; 1 = master must hold request.
- `resp_valid` out 1: 1 in the single completion cycle.
- `resp_err` out 1: completion cycle of an out-of-range access.

## Operation
- States: IDLE, WAIT, DONE (reset → IDLE).
- IDLE: `req_en`=0 → stay, `stall`=0. `req_en`=1 → `stall`=1. If WAIT_CYCLES=0, perform access this edge and go to DONE. Otherwise load `cnt`=WAIT_CYCLES−1 and go to WAIT.
- WAIT: `stall`=`req_en`. `req_en`=0 (master flush) → IDLE, no write, no response. `cnt`≠0 → decrement. `cnt`=0 → perform access at this edge and go to DONE.
- Access: word index = (`req_addr`−BASE_ADDR)>>2. In range: registered read into `rdata_q` (old contents, read-before-write), then enabled byte lanes written. Out of range: no write, `rdata_q`=0, `err_q`=1.
- DONE: `stall`=0, `resp_valid`=1, `rdata`=`rdata_q`, `resp_err`=`err_q`. Next edge → IDLE unconditionally; a new request is recognised only from IDLE.
- Outside DONE: `rdata` is held at its last value; `resp_err`=0.
- Address arithmetic is modulo 2^32; a word index ≥ 2^DEPTH_LOG2 is out of range, including a wrapped result below BASE_ADDR.

## Timing
- Reset values: state IDLE, `cnt` 0, `rdata` 0, `stall` 0 (given `req_en`=0), `resp_valid` 0, `resp_err` 0. The array is not reset.
- Request first seen in cycle 0: `stall` is high in cycles 0..WAIT_CYCLES and the response appears in cycle WAIT_CYCLES+1. Minimum stall is 1 cycle.
- Back-to-back requests: one idle gap cycle (IDLE) after every DONE.
- `resetn` falling mid-WAIT: immediate return to IDLE, no array write.
- Changing `req_*` during WAIT with `req_en`=1 is a protocol violation; the access uses the values present at the access edge.

## Configuration
- `SRAM_RESP_JITTER_EN` defined: a 16-bit Galois LFSR (taps 16,14,13,11; seed 16'hACE1; reset to seed) advances once per accepted request. Its low 2 bits add 0..3 wait states on top of WAIT_CYCLES, sampled in IDLE at request accept.
- Undefined: latency is exactly WAIT_CYCLES+1 and the LFSR logic is absent.

## Structure
- Package `sram_resp_pkg`: state enum {IDLE, WAIT, DONE}, `WAIT_W`=6, LFSR seed and tap constants.
- Sub-module `sram_resp_array`: synchronous single-port 32-bit array with 4 byte-lane write enables and read-before-write output register. FSM, counter and LFSR stay in the top module.

## Test plan
- WAIT_CYCLES=2, write 32'hDEADBEEF to addr 0x10 with `req_wen`=4'hF → `stall` high 3 cycles, `resp_valid` in cycle 3; a read of 0x10 then returns 32'hDEADBEEF.
- Byte-lane write `req_wen`=4'b0010, data 32'h0000AB00, to a word holding 32'h11223344 → a later read returns 32'h1122AB44.
- WAIT_CYCLES=0, consecutive reads of 0x0 and 0x4 → each stalls 1 cycle, one IDLE gap between the two DONE cycles.
- `req_en` dropped in the second WAIT cycle of a write → no `resp_valid`; the word is unchanged on readback.
- Address BASE_ADDR+4·2^DEPTH_LOG2 → `resp_err`=1, `rdata`=0, array unchanged; `resetn` pulsed mid-WAIT → `stall`/`resp_valid` 0 next cycle.
- `SRAM_RESP_JITTER_EN` build, 100 reads → every latency lies in [WAIT_CYCLES+1, WAIT_CYCLES+4] and the sequence matches the reference LFSR from seed 16'hACE1.
